// File: rtl/imem_sequencer.sv
// Instruction memory owner for the 4-bit core: loads a program from a byte stream,
// holds the core in reset, runs it free or single-step, and flags a halt when PC stalls.
module imem_sequencer #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned HALT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    input  logic              restart,
    input  logic              step_mode,
    input  logic              step,
    input  logic [ADDR_W-1:0] pc,
    output logic [7:0]        instr,
    output logic              core_rstn,
    output logic              core_en,
    output logic              halted,
    output logic [ADDR_W:0]   load_count,
    output logic [2:0]        state
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   count_d;
    logic [7:0]         hold_q, hold_d;
    logic [7:0]         same_q, same_d;
    logic [ADDR_W-1:0]  pc_prev_q, pc_prev_d;
    logic               have_prev_q, have_prev_d;
    logic               core_en_d;
    logic               xfer;
    logic               pc_same;
    logic [7:0]         mem [DEPTH];

    assign xfer    = (state_q == S_LOAD) && load_valid && load_ready;
    assign pc_same = have_prev_q && (pc == pc_prev_q);

    // Next-state, counters and next values of the registered outputs
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = load_count;
        hold_d      = hold_q;
        same_d      = same_q;
        pc_prev_d   = pc_prev_q;
        have_prev_d = have_prev_q;
        core_en_d   = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (load_start)   state_d = S_LOAD;
                else if (restart) state_d = S_HOLD;
            end
            S_LOAD: begin
                if (xfer) begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    count_d = load_count + CNT_W'(1);
                    if (load_last || (ptr_q == {ADDR_W{1'b1}})) state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (hold_q == 8'(HOLD_CYCLES - 1)) state_d = S_RUN;
                else                               hold_d  = hold_q + 8'd1;
            end
            S_RUN: begin
                if (load_start)   state_d = S_LOAD;
                else if (restart) state_d = S_HOLD;
                else if (core_en) begin
                    // The first enabled cycle only captures PC; later ones compare
                    if (have_prev_q) same_d = pc_same ? same_q + 8'd1 : 8'd0;
                    pc_prev_d   = pc;
                    have_prev_d = 1'b1;
                    if (pc_same && (same_q == 8'(HALT_CYCLES - 1))) state_d = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // State-entry initialisation
        if (state_d == S_LOAD && state_q != S_LOAD) begin
            ptr_d   = '0;
            count_d = '0;
        end
        if (state_d == S_HOLD && state_q != S_HOLD) hold_d = '0;
        if (state_d == S_RUN && state_q != S_RUN) begin
            same_d      = '0;
            have_prev_d = 1'b0;
        end

        // Step pulses only count once already running; a step during an enable is dropped
        if (state_d == S_RUN)
            core_en_d = step_mode ? (state_q == S_RUN && step && !core_en) : 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            load_count  <= '0;
            hold_q      <= '0;
            same_q      <= '0;
            pc_prev_q   <= '0;
            have_prev_q <= 1'b0;
            load_ready  <= 1'b0;
            core_rstn   <= 1'b0;
            core_en     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            load_count  <= count_d;
            hold_q      <= hold_d;
            same_q      <= same_d;
            pc_prev_q   <= pc_prev_d;
            have_prev_q <= have_prev_d;
            load_ready  <= (state_d == S_LOAD);
            core_rstn   <= (state_d == S_RUN) || (state_d == S_HALT);
            core_en     <= core_en_d;
            halted      <= (state_d == S_HALT);
        end
    end

    // Program storage; contents survive reset
    always_ff @(posedge clk) begin
        if (xfer) mem[ptr_q] <= load_data;
    end

    assign instr = mem[pc];
    assign state = state_q;

endmodule

// File: doc/imem_sequencer.md
Name: imem_sequencer

Overview:
- Owns the 128 x 8 instruction memory of the 4-bit core and sequences it through load, reset, run and halt.
- Accepts a program as a valid/ready byte stream, then holds the core in reset for a fixed count, then releases it.
- Runs the core free or single-step through a clock-enable, and detects a halt when PC stops changing.
- Sits between the system host/loader and the core's PC/INSTR/RSTN pins.

Parameters:
- ADDR_W, 7, instruction address width; memory depth is 2**ADDR_W.
- HOLD_CYCLES, 10, cycles CORE_RSTN is held low before each run (valid range 1..255).
- HALT_CYCLES, 4, consecutive enabled cycles with an unchanged PC that declare a halt (valid range 1..255).

Ports:
- CLK  in  1  clock.
- RSTN  in  1  asynchronous active-low reset.
- LOAD_START  in  1  pulse: begin a program load.
- LOAD_VALID  in  1  byte-stream valid.
- LOAD_READY  out  1  byte-stream ready.
- LOAD_DATA  in  8  instruction byte.
- LOAD_LAST  in  1  marks the final byte of the program.
- RESTART  in  1  pulse: re-run the loaded program.
- STEP_MODE  in  1  1 = single-step, 0 = free run.
- STEP  in  1  pulse: advance one core cycle in step mode.
- PC  in  ADDR_W  core program counter.
- INSTR  out  8  mem[PC], combinational.
- CORE_RSTN  out  1  core reset, active-low, registered.
- CORE_EN  out  1  core clock enable, registered.
- HALTED  out  1  core is halted.
- LOAD_COUNT  out  ADDR_W+1  bytes accepted by the last load (0..128).
- STATE  out  3  encoded FSM state, for debug.

Behaviour:
- States and encodings: IDLE=0, LOAD=1, HOLD=2, RUN=3, HALT=4.
- Reset values (asynchronous, RSTN low):
  - state IDLE; CORE_RSTN=0, CORE_EN=0, HALTED=0, LOAD_READY=0, LOAD_COUNT=0.
  - Write pointer, hold counter and halt counter all 0.
  - Memory contents are not reset.
- IDLE:
  - CORE_RSTN=0.
  - LOAD_START -> LOAD.
  - RESTART -> HOLD.
- LOAD:
  - On entry, write pointer and LOAD_COUNT are cleared to 0.
  - LOAD_READY=1 throughout the state.
  - Transfer occurs when LOAD_VALID and LOAD_READY are both high: mem[ptr] <= LOAD_DATA, ptr++, LOAD_COUNT++.
  - A transfer with LOAD_LAST=1, or a transfer at ptr=127, ends the load -> HOLD. LOAD_READY drops the next cycle.
  - Addresses that are not written keep their old contents.
  - CORE_RSTN=0 throughout the state.
- HOLD:
  - CORE_RSTN=0 and CORE_EN=0.
  - The counter runs HOLD_CYCLES cycles, then -> RUN.
  - CORE_RSTN rises on the first RUN cycle.
- RUN:
  - CORE_RSTN=1.
  - Free run (STEP_MODE=0): CORE_EN=1.
  - Step mode (STEP_MODE=1): CORE_EN is a one-cycle pulse, registered one cycle after each STEP pulse. STEP while CORE_EN is already high is dropped.
  - A STEP_MODE change takes effect on the next cycle.
- Halt detection:
  - Evaluated only on cycles where CORE_EN=1.
  - Compare PC with the PC sampled at the previous enabled cycle. Equal: halt counter +1. Different: halt counter cleared.
  - There is no comparison on the first enabled cycle after entering RUN.
  - Halt counter reaching HALT_CYCLES -> HALT.
- HALT:
  - CORE_EN=0, CORE_RSTN stays 1 so OPORT is preserved, HALTED=1.
  - RESTART -> HOLD with HALTED cleared.
  - LOAD_START -> LOAD.
- Priority:
  - LOAD_START beats RESTART in the same cycle.
  - LOAD_START or RESTART in RUN aborts the run to LOAD or HOLD respectively, dropping CORE_RSTN to 0 the next cycle.
  - LOAD_START or RESTART during LOAD or HOLD is ignored.
  - STEP outside RUN is ignored.
- Reset mid-load: everything returns to IDLE immediately; partial memory writes remain.
- INSTR is valid in every state, including while the core is in reset.

Test Plan:
- Load 4 bytes {A1,B2,C3,D4} with LAST on the 4th -> LOAD_COUNT=4, mem[0..3] match; HOLD holds CORE_RSTN=0 for 10 cycles, then RUN with CORE_EN=1; PC=2 gives INSTR=C3.
- Load 128 bytes with LAST never asserted -> the load ends at ptr=127, LOAD_COUNT=128, LOAD_READY=0 the cycle after the 128th transfer.
- Backpressure: LOAD_VALID toggling every other cycle with random gaps -> only handshake cycles write; LOAD_COUNT equals the number of transfers.
- Free run, PC stuck at 0x05 -> HALTED=1 after 4 equal-PC enabled cycles; CORE_EN=0, CORE_RSTN stays 1. A PC change on the 3rd cycle clears the counter and there is no halt.
- Step mode: 3 STEP pulses -> exactly 3 one-cycle CORE_EN pulses, each one cycle after its STEP. STEP in HOLD produces no pulse.
- LOAD_START and RESTART in the same RUN cycle -> LOAD entered, CORE_RSTN=0 next cycle. RSTN low mid-load -> IDLE with all outputs at reset values.
